// File: rtl/easyaxi_rd_mst_ost_if.sv
// rtl/easyaxi_rd_mst_ost_if.sv - command, AR, R and result channels of the outstanding AXI read master
interface easyaxi_rd_mst_ost_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LW     = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;

  logic              axi_mst_arvalid;
  logic              axi_mst_arready;
  logic [ID_W-1:0]   axi_mst_arid;
  logic [ADDR_W-1:0] axi_mst_araddr;
  logic [7:0]        axi_mst_arlen;
  logic [2:0]        axi_mst_arsize;
  logic [1:0]        axi_mst_arburst;

  logic              axi_mst_rvalid;
  logic              axi_mst_rready;
  logic [ID_W-1:0]   axi_mst_rid;
  logic [DATA_W-1:0] axi_mst_rdata;
  logic [1:0]        axi_mst_rresp;
  logic              axi_mst_rlast;

  logic              res_valid;
  logic              res_ready;
  logic [ID_W-1:0]   res_id;
  logic [1:0]        res_resp;
  logic [LW:0]       res_beats;
  logic [DATA_W-1:0] res_csum;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
    output cmd_ready,
    output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst,
    input  axi_mst_arready,
    input  axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    output axi_mst_rready,
    output res_valid, res_id, res_resp, res_beats, res_csum,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
    input  cmd_ready,
    input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst,
    output axi_mst_arready,
    output axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    input  axi_mst_rready,
    input  res_valid, res_id, res_resp, res_beats, res_csum,
    output res_ready
  );
endinterface

// File: rtl/easyaxi_rd_mst_ost.sv
// rtl/easyaxi_rd_mst_ost.sv - AXI read master with a slot buffer of outstanding bursts
// Commands allocate slots in order, R beats land by slot ID, results retire in command order.
module easyaxi_rd_mst_ost #(
  parameter int OST_DEPTH     = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int ID_W          = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  easyaxi_rd_mst_ost_if.master       bus,
  output logic [$clog2(OST_DEPTH):0] o_ost_cnt,
  output logic                       o_proto_err
);
  localparam int OW = $clog2(OST_DEPTH);
  localparam int LW = $clog2(MAX_BURST_LEN);
  localparam logic [OW-1:0] PTR_ONE  = OW'(1);
  localparam logic [OW:0]   CNT_ONE  = (OW+1)'(1);
  localparam logic [LW:0]   BEAT_ONE = (LW+1)'(1);

  typedef enum logic [1:0] {S_FREE, S_ISSUE, S_WAIT, S_DONE} slot_st_e;

  slot_st_e          r_state     [OST_DEPTH];
  slot_st_e          w_state_nxt [OST_DEPTH];
  logic [ADDR_W-1:0] r_addr      [OST_DEPTH];
  logic [LW-1:0]     r_len       [OST_DEPTH];
  logic [2:0]        r_size      [OST_DEPTH];
  logic [1:0]        r_burst     [OST_DEPTH];
  logic [1:0]        r_resp      [OST_DEPTH];
  logic [LW:0]       r_beats     [OST_DEPTH];
  logic [DATA_W-1:0] r_csum      [OST_DEPTH];

  logic [OW-1:0] r_set_ptr;
  logic [OW-1:0] r_req_ptr;
  logic [OW-1:0] r_clr_ptr;
  logic [OW:0]   r_ost_cnt;
  logic          r_proto_err;

  logic          w_full;
  logic          w_cmd_acc;
  logic          w_arvalid;
  logic          w_ar_hs;
  logic          w_res_valid;
  logic          w_res_hs;
  logic [OW-1:0] w_r_slot;
  logic          w_r_hi_ok;
  logic          w_r_acc;
  logic [LW:0]   w_len_p1;
  logic [LW:0]   w_beats_p1;
  logic          w_r_room;
  logic          w_err;

  // Occupancy tops out at OST_DEPTH, so its MSB alone means every slot is taken.
  assign w_full      = r_ost_cnt[OW];
  assign w_cmd_acc   = bus.cmd_valid & ~w_full;
  assign w_arvalid   = (r_state[r_req_ptr] == S_ISSUE);
  assign w_ar_hs     = w_arvalid & bus.axi_mst_arready;
  assign w_res_valid = (r_state[r_clr_ptr] == S_DONE);
  assign w_res_hs    = w_res_valid & bus.res_ready;

  assign w_r_slot   = bus.axi_mst_rid[OW-1:0];
  assign w_r_hi_ok  = ((bus.axi_mst_rid >> OW) == '0);
  assign w_r_acc    = bus.axi_mst_rvalid & w_r_hi_ok & (r_state[w_r_slot] == S_WAIT);
  assign w_len_p1   = {1'b0, r_len[w_r_slot]} + BEAT_ONE;
  assign w_beats_p1 = r_beats[w_r_slot] + BEAT_ONE;
  // Once a burst has its full beat count, surplus beats are dropped until rlast closes it.
  assign w_r_room   = (r_beats[w_r_slot] != w_len_p1);

  assign w_err = (bus.axi_mst_rvalid & ~w_r_acc)
               | (w_r_acc &  bus.axi_mst_rlast & (w_beats_p1 != w_len_p1))
               | (w_r_acc & ~bus.axi_mst_rlast & ~w_r_room);

  always_comb begin
    for (int i = 0; i < OST_DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_cmd_acc && (r_set_ptr == OW'(i)))
        w_state_nxt[i] = S_ISSUE;
      if (w_ar_hs && (r_req_ptr == OW'(i)))
        w_state_nxt[i] = S_WAIT;
      if (w_r_acc && bus.axi_mst_rlast && (w_r_slot == OW'(i)))
        w_state_nxt[i] = S_DONE;
      if (w_res_hs && (r_clr_ptr == OW'(i)))
        w_state_nxt[i] = S_FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OST_DEPTH; i++)
        r_state[i] <= S_FREE;
    end else begin
      for (int i = 0; i < OST_DEPTH; i++)
        r_state[i] <= w_state_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_len[i]   <= '0;
        r_size[i]  <= '0;
        r_burst[i] <= '0;
        r_resp[i]  <= '0;
        r_beats[i] <= '0;
        r_csum[i]  <= '0;
      end
    end else begin
      if (w_cmd_acc) begin
        r_addr[r_set_ptr]  <= bus.cmd_addr;
        r_len[r_set_ptr]   <= bus.cmd_len;
        r_size[r_set_ptr]  <= bus.cmd_size;
        r_burst[r_set_ptr] <= bus.cmd_burst;
        r_resp[r_set_ptr]  <= '0;
        r_beats[r_set_ptr] <= '0;
        r_csum[r_set_ptr]  <= '0;
      end
      if (w_r_acc && w_r_room) begin
        r_beats[w_r_slot] <= w_beats_p1;
        r_csum[w_r_slot]  <= r_csum[w_r_slot] ^ bus.axi_mst_rdata;
        if (bus.axi_mst_rresp > r_resp[w_r_slot])
          r_resp[w_r_slot] <= bus.axi_mst_rresp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_ptr   <= '0;
      r_req_ptr   <= '0;
      r_clr_ptr   <= '0;
      r_ost_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_cmd_acc) r_set_ptr <= r_set_ptr + PTR_ONE;
      if (w_ar_hs)   r_req_ptr <= r_req_ptr + PTR_ONE;
      if (w_res_hs)  r_clr_ptr <= r_clr_ptr + PTR_ONE;
      case ({w_cmd_acc, w_res_hs})
        2'b10:   r_ost_cnt <= r_ost_cnt + CNT_ONE;
        2'b01:   r_ost_cnt <= r_ost_cnt - CNT_ONE;
        default: r_ost_cnt <= r_ost_cnt;
      endcase
      if (w_err) r_proto_err <= 1'b1;
    end
  end

  assign bus.cmd_ready       = ~w_full;
  assign bus.axi_mst_arvalid = w_arvalid;
  assign bus.axi_mst_arid    = ID_W'(r_req_ptr);
  assign bus.axi_mst_araddr  = r_addr[r_req_ptr];
  assign bus.axi_mst_arlen   = 8'(r_len[r_req_ptr]);
  assign bus.axi_mst_arsize  = r_size[r_req_ptr];
  assign bus.axi_mst_arburst = r_burst[r_req_ptr];
  assign bus.axi_mst_rready  = 1'b1;
  assign bus.res_valid       = w_res_valid;
  assign bus.res_id          = ID_W'(r_clr_ptr);
  assign bus.res_resp        = r_resp[r_clr_ptr];
  assign bus.res_beats       = r_beats[r_clr_ptr];
  assign bus.res_csum        = r_csum[r_clr_ptr];
  assign o_ost_cnt           = r_ost_cnt;
  assign o_proto_err         = r_proto_err;
endmodule

// File: tb/tb_easyaxi_rd_mst_ost.sv
// tb/tb_easyaxi_rd_mst_ost.sv - directed table and sequence checks for easyaxi_rd_mst_ost
module tb_easyaxi_rd_mst_ost;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ost_cnt;
  logic       proto_err;
  int         n_chk = 0;
  int         n_err = 0;

  easyaxi_rd_mst_ost_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LW(4)) bus ();

  easyaxi_rd_mst_ost #(
    .OST_DEPTH(8), .MAX_BURST_LEN(16), .ID_W(4), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_ost_cnt(ost_cnt), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [4:0]  beats;
    logic [31:0] csum;
  } res_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [3:0][31:0] data;
    logic [3:0][1:0]  resp;
    logic [1:0]       e_resp;
    logic [4:0]       e_beats;
    logic [31:0]      e_csum;
  } vec_t;

  res_t       res_q[$];
  logic [3:0] ar_q[$];
  vec_t       vecs[4];

  always @(negedge clk) begin
    res_t tmp;
    #4;
    if (rst_n && bus.axi_mst_arvalid && bus.axi_mst_arready)
      ar_q.push_back(bus.axi_mst_arid);
    if (rst_n && bus.res_valid && bus.res_ready) begin
      tmp.id    = bus.res_id;
      tmp.resp  = bus.res_resp;
      tmp.beats = bus.res_beats;
      tmp.csum  = bus.res_csum;
      res_q.push_back(tmp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cmd_valid      = 1'b0;
    bus.axi_mst_rvalid = 1'b0;
    bus.axi_mst_rlast  = 1'b0;
    bus.res_ready      = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    res_q.delete();
    ar_q.delete();
  endtask

  task automatic do_cmd(input logic [31:0] addr, input logic [3:0] len);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = 3'd2;
    bus.cmd_burst = 2'd1;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (bus.cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1);
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] r, input bit last);
    bus.axi_mst_rvalid = 1'b1;
    bus.axi_mst_rid    = id;
    bus.axi_mst_rdata  = d;
    bus.axi_mst_rresp  = r;
    bus.axi_mst_rlast  = last;
    @(negedge clk);
    bus.axi_mst_rvalid = 1'b0;
    bus.axi_mst_rlast  = 1'b0;
  endtask

  task automatic wait_res(input int n);
    for (int t = 0; t < 200 && res_q.size() < n; t++)
      @(negedge clk);
    chk("res_count", res_q.size(), n);
  endtask

  task automatic chk_res(input int idx, input logic [3:0] id, input logic [1:0] resp,
                         input logic [4:0] beats, input logic [31:0] csum);
    res_t r;
    r = 'x;
    if (idx < res_q.size()) r = res_q[idx];
    chk("res_id", r.id, id);
    chk("res_resp", r.resp, resp);
    chk("res_beats", r.beats, beats);
    chk("res_csum", r.csum, csum);
  endtask

  initial begin
    // data/resp packed as {beat3, beat2, beat1, beat0}
    vecs[0] = '{addr: 32'h100, len: 4'd3,
                data: {32'h4, 32'h3, 32'h2, 32'h1}, resp: {2'd0, 2'd0, 2'd0, 2'd0},
                e_resp: 2'd0, e_beats: 5'd4, e_csum: 32'h0000_0004};
    vecs[1] = '{addr: 32'h2000, len: 4'd3,
                data: {32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_5A5A, 32'hA5A5_0000},
                resp: {2'd1, 2'd0, 2'd2, 2'd0},
                e_resp: 2'd2, e_beats: 5'd4, e_csum: 32'h486E_F3DD};
    vecs[2] = '{addr: 32'h3000_0040, len: 4'd0,
                data: {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, resp: {2'd0, 2'd0, 2'd0, 2'd3},
                e_resp: 2'd3, e_beats: 5'd1, e_csum: 32'hDEAD_BEEF};
    vecs[3] = '{addr: 32'h44, len: 4'd1,
                data: {32'h0, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F}, resp: {2'd0, 2'd0, 2'd0, 2'd1},
                e_resp: 2'd1, e_beats: 5'd2, e_csum: 32'hFFFF_FFFF};

    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_size = '0; bus.cmd_burst = '0;
    bus.axi_mst_arready = 1'b1;
    bus.axi_mst_rvalid = 1'b0; bus.axi_mst_rid = '0; bus.axi_mst_rdata = '0;
    bus.axi_mst_rresp = '0; bus.axi_mst_rlast = 1'b0;
    bus.res_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_arvalid", bus.axi_mst_arvalid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_ost_cnt", ost_cnt, 0);
    chk("rst_araddr", bus.axi_mst_araddr, 0);
    chk("rst_res_csum", bus.res_csum, 0);
    chk("rst_rready", bus.axi_mst_rready, 1);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      res_q.delete();
      do_cmd(vecs[v].addr, vecs[v].len);
      chk("vec_arvalid", bus.axi_mst_arvalid, 1);
      chk("vec_araddr", bus.axi_mst_araddr, vecs[v].addr);
      chk("vec_arlen", bus.axi_mst_arlen, {4'd0, vecs[v].len});
      chk("vec_arid", bus.axi_mst_arid, v);
      @(negedge clk);
      for (int k = 0; k <= int'(vecs[v].len); k++)
        send_beat(4'(v), vecs[v].data[k], vecs[v].resp[k], k == int'(vecs[v].len));
      wait_res(1);
      chk_res(0, 4'(v), vecs[v].e_resp, vecs[v].e_beats, vecs[v].e_csum);
      chk("vec_ost_cnt", ost_cnt, 0);
    end
    chk("vec_proto_err", proto_err, 0);

    // Fill all slots, retire slot 0, confirm wrap to ARID 0
    do_reset();
    for (int i = 0; i < 8; i++) do_cmd(32'h1000 + 32'(i * 64), 4'd0);
    chk("fill_ost_cnt", ost_cnt, 8);
    chk("fill_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    chk("fill_ar_cnt", ar_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("fill_arid", (i < ar_q.size()) ? ar_q[i] : 4'hx, i);
    send_beat(4'd0, 32'h55, 2'd0, 1'b1);
    chk("fill_res_valid", bus.res_valid, 1);
    chk("fill_ready_same_cycle", bus.cmd_ready, 0);
    @(negedge clk);
    chk("fill_ready_next", bus.cmd_ready, 1);
    chk("fill_ost_after_retire", ost_cnt, 7);
    ar_q.delete();
    do_cmd(32'h2000, 4'd0);
    @(negedge clk);
    chk("wrap_arid", (ar_q.size() > 0) ? ar_q[0] : 4'hx, 0);
    chk("wrap_ost_cnt", ost_cnt, 8);

    // Out-of-order completion 2,0,1 retires as 0,1,2
    do_reset();
    for (int i = 0; i < 3; i++) do_cmd(32'h400 + 32'(i * 16), 4'd1);
    @(negedge clk);
    send_beat(4'd2, 32'h22, 2'd0, 1'b0);
    send_beat(4'd2, 32'h20, 2'd0, 1'b1);
    chk("ooo_head_blocks", bus.res_valid, 0);
    send_beat(4'd0, 32'h100, 2'd0, 1'b0);
    send_beat(4'd0, 32'h001, 2'd0, 1'b1);
    chk("ooo_res_valid_m1", bus.res_valid, 1);
    chk("ooo_res_id_m1", bus.res_id, 0);
    send_beat(4'd1, 32'hF0, 2'd0, 1'b0);
    send_beat(4'd1, 32'h0F, 2'd0, 1'b1);
    wait_res(3);
    chk_res(0, 4'd0, 2'd0, 5'd2, 32'h101);
    chk_res(1, 4'd1, 2'd0, 5'd2, 32'hFF);
    chk_res(2, 4'd2, 2'd0, 5'd2, 32'h02);

    // Backpressure: held results stay stable while new commands still enter
    do_reset();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_cmd(32'h800 + 32'(i * 16), 4'd0);
    @(negedge clk);
    send_beat(4'd0, 32'hA, 2'd0, 1'b1);
    send_beat(4'd1, 32'hB, 2'd0, 1'b1);
    send_beat(4'd2, 32'hC, 2'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {bus.res_valid, bus.res_id, bus.res_beats, bus.res_csum}, {1'b1, 4'd0, 5'd1, 32'hA});
      @(negedge clk);
    end
    do_cmd(32'h900, 4'd0);
    do_cmd(32'h910, 4'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold", {bus.res_valid, bus.res_id, bus.res_beats, bus.res_csum}, {1'b1, 4'd0, 5'd1, 32'hA});
      @(negedge clk);
    end
    chk("bp_ost_cnt", ost_cnt, 5);
    bus.res_ready = 1'b1;
    wait_res(3);
    chk_res(0, 4'd0, 2'd0, 5'd1, 32'hA);
    chk_res(1, 4'd1, 2'd0, 5'd1, 32'hB);
    chk_res(2, 4'd2, 2'd0, 5'd1, 32'hC);
    chk("bp_ost_drain", ost_cnt, 2);

    // Beat to a FREE slot
    do_reset();
    send_beat(4'd5, 32'h1, 2'd0, 1'b1);
    chk("pe_free_err", proto_err, 1);
    chk("pe_free_ost", ost_cnt, 0);
    chk("pe_free_res_valid", bus.res_valid, 0);

    // Nonzero upper RID bits are dropped
    do_reset();
    do_cmd(32'h300, 4'd0);
    @(negedge clk);
    send_beat(4'd8, 32'h7, 2'd0, 1'b1);
    chk("pe_hi_err", proto_err, 1);
    chk("pe_hi_res_valid", bus.res_valid, 0);
    chk("pe_hi_ost", ost_cnt, 1);
    send_beat(4'd0, 32'h9, 2'd0, 1'b1);
    wait_res(1);
    chk_res(0, 4'd0, 2'd0, 5'd1, 32'h9);

    // Early rlast on beat 2 of a 4-beat burst
    do_reset();
    do_cmd(32'h400, 4'd3);
    @(negedge clk);
    send_beat(4'd0, 32'h11, 2'd0, 1'b0);
    chk("pe_early_before", proto_err, 0);
    send_beat(4'd0, 32'h22, 2'd0, 1'b1);
    chk("pe_early_err", proto_err, 1);
    wait_res(1);
    chk_res(0, 4'd0, 2'd0, 5'd2, 32'h33);

    // Overflow: extra beats after len+1 are dropped until rlast
    do_reset();
    do_cmd(32'h500, 4'd1);
    @(negedge clk);
    send_beat(4'd0, 32'h1, 2'd0, 1'b0);
    send_beat(4'd0, 32'h2, 2'd0, 1'b0);
    chk("pe_ovf_before", proto_err, 0);
    chk("pe_ovf_no_res", bus.res_valid, 0);
    send_beat(4'd0, 32'h4, 2'd0, 1'b0);
    chk("pe_ovf_err", proto_err, 1);
    send_beat(4'd0, 32'h8, 2'd0, 1'b1);
    wait_res(1);
    chk_res(0, 4'd0, 2'd0, 5'd2, 32'h3);

    // Reset mid-burst frees everything; later beats are unexpected
    do_reset();
    do_cmd(32'h600, 4'd3);
    @(negedge clk);
    send_beat(4'd0, 32'h1, 2'd0, 1'b0);
    do_reset();
    chk("mid_rst_ost", ost_cnt, 0);
    chk("mid_rst_arvalid", bus.axi_mst_arvalid, 0);
    chk("mid_rst_err_clear", proto_err, 0);
    send_beat(4'd0, 32'h2, 2'd0, 1'b1);
    chk("mid_rst_err", proto_err, 1);
    chk("mid_rst_res_valid", bus.res_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
